// File: rtl/bp_resolve_queue_if.sv
// Handshake bundle between the branch predictor / execute side and the resolve queue.
// master drives predictions and resolutions; slave is the queue.
interface bp_resolve_queue_if;
  logic pred_valid;
  logic pred_taken;
  logic pred_ready;
  logic res_valid;
  logic res_taken;
  logic update_valid;
  logic update_result;
  logic mispredict;

  modport master (
    output pred_valid, pred_taken, res_valid, res_taken,
    input  pred_ready, update_valid, update_result, mispredict
  );

  modport slave (
    input  pred_valid, pred_taken, res_valid, res_taken,
    output pred_ready, update_valid, update_result, mispredict
  );
endinterface

// File: rtl/bp_resolve_queue.sv
// In-flight branch prediction queue: pops on resolution, flags and flushes on
// mispredict, feeds the outcome back to the predictor, keeps saturating stats.
module bp_resolve_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2,
  parameter int CNT_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  bp_resolve_queue_if.slave  bus,
  output logic               o_orphan_err,
  output logic [PTR_W:0]     o_occupancy,
  output logic [CNT_W-1:0]   o_cnt_total,
  output logic [CNT_W-1:0]   o_cnt_miss
);
  localparam logic [PTR_W:0] FULL = DEPTH[PTR_W:0];

  logic [DEPTH-1:0] r_mem;
  logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
  logic [PTR_W:0]   r_occ;
  logic             r_upd_vld, r_upd_res, r_misp, r_orphan;
  logic [CNT_W-1:0] r_cnt_total, r_cnt_miss;

  logic             w_push, w_pop, w_empty, w_miss;
  logic [PTR_W-1:0] w_wr_nxt;

  assign w_empty  = (r_occ == '0);
  assign w_push   = bus.pred_valid & (r_occ != FULL);
  assign w_pop    = bus.res_valid & ~w_empty;
  assign w_miss   = w_pop & (r_mem[r_rd_ptr] != bus.res_taken);
  assign w_wr_nxt = w_push ? r_wr_ptr + PTR_W'(1) : r_wr_ptr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mem       <= '0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_occ       <= '0;
      r_upd_vld   <= 1'b0;
      r_upd_res   <= 1'b0;
      r_misp      <= 1'b0;
      r_orphan    <= 1'b0;
      r_cnt_total <= '0;
      r_cnt_miss  <= '0;
    end else begin
      if (w_push) r_mem[r_wr_ptr] <= bus.pred_taken;
      r_wr_ptr  <= w_wr_nxt;
      r_upd_vld <= w_pop;
      r_upd_res <= w_pop & bus.res_taken;
      r_misp    <= w_miss;
      r_orphan  <= r_orphan | (bus.res_valid & w_empty);
      // A wrong head invalidates everything younger, including this cycle's push.
      if (w_miss) begin
        r_rd_ptr <= w_wr_nxt;
        r_occ    <= '0;
      end else if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_occ    <= r_occ + (PTR_W+1)'(w_push) - (PTR_W+1)'(1);
      end else begin
        r_occ    <= r_occ + (PTR_W+1)'(w_push);
      end
      if (w_pop && r_cnt_total != '1) r_cnt_total <= r_cnt_total + CNT_W'(1);
      if (w_miss && r_cnt_miss != '1) r_cnt_miss <= r_cnt_miss + CNT_W'(1);
    end
  end

  assign bus.pred_ready    = (r_occ != FULL);
  assign bus.update_valid  = r_upd_vld;
  assign bus.update_result = r_upd_res;
  assign bus.mispredict    = r_misp;
  assign o_orphan_err      = r_orphan;
  assign o_occupancy       = r_occ;
  assign o_cnt_total       = r_cnt_total;
  assign o_cnt_miss        = r_cnt_miss;
endmodule

// File: tb/tb_bp_resolve_queue.sv
// Directed bench for bp_resolve_queue: hand-computed expectations checked with
// immediate assertions one cycle after each driving edge.
module tb_bp_resolve_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        orphan_err;
  logic [2:0]  occupancy;
  logic [15:0] cnt_total, cnt_miss;
  int          checks = 0;
  int          errors = 0;
  int          exp_miss;
  logic [11:0] pvec;
  logic        rbit;

  bp_resolve_queue_if bif ();

  bp_resolve_queue #(.DEPTH(4), .PTR_W(2), .CNT_W(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .bus          (bif.slave),
    .o_orphan_err (orphan_err),
    .o_occupancy  (occupancy),
    .o_cnt_total  (cnt_total),
    .o_cnt_miss   (cnt_miss)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt);
    bif.pred_valid = pv;
    bif.pred_taken = pt;
    bif.res_valid  = rv;
    bif.res_taken  = rt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    chk("rst_occ", occupancy, 0);
    chk("rst_ready", bif.pred_ready, 1);
    chk("rst_upd", bif.update_valid, 0);
    chk("rst_res", bif.update_result, 0);
    chk("rst_misp", bif.mispredict, 0);
    chk("rst_orphan", orphan_err, 0);
    chk("rst_total", cnt_total, 0);
    chk("rst_miss", cnt_miss, 0);

    // 1: push T,T,N
    drive(1, 1, 0, 0); tick();
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 0, 0);
    chk("t1_occ", occupancy, 3);
    chk("t1_ready", bif.pred_ready, 1);
    chk("t1_upd", bif.update_valid, 0);
    chk("t1_misp", bif.mispredict, 0);

    // 2: fill to 4, 5th offered while full is ignored, then correct pop of head T
    drive(1, 1, 0, 0); tick();
    chk("t2_full_occ", occupancy, 4);
    chk("t2_full_ready", bif.pred_ready, 0);
    drive(1, 0, 0, 0); tick();
    chk("t2_5th_occ", occupancy, 4);
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 0);
    chk("t2_upd", bif.update_valid, 1);
    chk("t2_res", bif.update_result, 1);
    chk("t2_misp", bif.mispredict, 0);
    chk("t2_occ", occupancy, 3);
    chk("t2_ready", bif.pred_ready, 1);
    chk("t2_total", cnt_total, 1);
    tick();
    chk("t2_upd_pulse", bif.update_valid, 0);

    // 3: queue T,N,N; resolve head as not-taken with a same-cycle push -> flush
    do_reset();
    drive(1, 1, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(1, 0, 0, 0); tick();
    drive(1, 1, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("t3_misp", bif.mispredict, 1);
    chk("t3_occ", occupancy, 0);
    chk("t3_miss", cnt_miss, 1);
    chk("t3_total", cnt_total, 1);
    chk("t3_upd", bif.update_valid, 1);
    chk("t3_res", bif.update_result, 0);
    tick();
    chk("t3_misp_pulse", bif.mispredict, 0);
    chk("t3_dropped_occ", occupancy, 0);
    // head after flush must be the new N, not a stale T
    drive(1, 0, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("t3_newhead_misp", bif.mispredict, 0);
    chk("t3_newhead_total", cnt_total, 2);

    // 4: resolution on empty queue with same-cycle push -> orphan, no pop
    drive(1, 1, 1, 1); tick();
    drive(0, 0, 0, 0);
    chk("t4_orphan", orphan_err, 1);
    chk("t4_occ", occupancy, 1);
    chk("t4_upd", bif.update_valid, 0);
    chk("t4_total", cnt_total, 2);
    tick();
    chk("t4_sticky", orphan_err, 1);
    drive(0, 0, 1, 1); tick();
    drive(0, 0, 0, 0);
    chk("t4_pop_total", cnt_total, 3);
    chk("t4_pop_misp", bif.mispredict, 0);

    // 5: 12 push/pop pairs, pointers wrap three times, outcomes alternate
    do_reset();
    pvec = 12'b1100_1010_0110;
    exp_miss = 0;
    for (int i = 0; i < 12; i++) begin
      rbit = (i % 2) == 1;
      drive(1, pvec[i], 0, 0); tick();
      drive(0, 0, 1, rbit); tick();
      drive(0, 0, 0, 0);
      if (pvec[i] != rbit) exp_miss++;
      chk($sformatf("t5_res_%0d", i), bif.update_result, rbit);
      chk($sformatf("t5_misp_%0d", i), bif.mispredict, pvec[i] != rbit);
    end
    chk("t5_total", cnt_total, 12);
    chk("t5_miss", cnt_miss, exp_miss);
    chk("t5_occ", occupancy, 0);

    // 6: miss counter saturation, then reset with entries held
    force dut.r_cnt_miss = 16'hFFFF;
    #1;
    release dut.r_cnt_miss;
    drive(1, 1, 0, 0); tick();
    drive(0, 0, 1, 0); tick();
    drive(0, 0, 0, 0);
    chk("t6_sat_misp", bif.mispredict, 1);
    chk("t6_sat_miss", cnt_miss, 16'hFFFF);
    chk("t6_sat_total", cnt_total, 13);
    drive(1, 1, 0, 0); tick();
    tick();
    tick();
    chk("t6_pre_occ", occupancy, 3);
    rst = 1'b1;
    drive(1, 0, 1, 1); tick();
    rst = 1'b0;
    drive(0, 0, 0, 0);
    chk("t6_rst_occ", occupancy, 0);
    chk("t6_rst_ready", bif.pred_ready, 1);
    chk("t6_rst_upd", bif.update_valid, 0);
    chk("t6_rst_misp", bif.mispredict, 0);
    chk("t6_rst_miss", cnt_miss, 0);
    chk("t6_rst_total", cnt_total, 0);
    tick();
    chk("t6_post_upd", bif.update_valid, 0);
    chk("t6_post_misp", bif.mispredict, 0);
    chk("t6_post_orphan", orphan_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
